// File: rtl/ysyx_23060236_mdu.sv
// Iterative RV32/64 M-extension multiply/divide unit with a valid/ready handshake and flush.
// Define YSYX_23060236_MDU_FASTMUL_EN to replace the shift-add multiplier with a single-cycle product.
module ysyx_23060236_mdu #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [TAG_W-1:0] rd_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_out
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [2:0]      f3_r;
    logic [XLEN-1:0] hi_r;
    logic [XLEN-1:0] lo_r;
    logic [XLEN-1:0] opnd_r;
    logic            q_neg_r;
    logic            r_neg_r;
    logic            quick_r;
    logic [CW-1:0]   cnt_r;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x, input logic en);
        return en ? (~x + XLEN'(1)) : x;
    endfunction

    logic            s1_signed_s;
    logic            s2_signed_s;
    logic            s1_neg_s;
    logic            s2_neg_s;
    logic [XLEN-1:0] mag1_s;
    logic [XLEN-1:0] mag2_s;
    logic            div_zero_s;
    logic            div_ovf_s;
    logic            quick_s;
    logic [XLEN-1:0] quick_res_s;

    // Operand signedness per op
    always_comb begin
        s1_signed_s = 1'b0;
        s2_signed_s = 1'b0;
        case (funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                s1_signed_s = 1'b1;
                s2_signed_s = 1'b1;
            end
            3'd2: begin
                s1_signed_s = 1'b1;
                s2_signed_s = 1'b0;
            end
            default: begin
                s1_signed_s = 1'b0;
                s2_signed_s = 1'b0;
            end
        endcase
    end

    assign s1_neg_s   = s1_signed_s & src1[XLEN-1];
    assign s2_neg_s   = s2_signed_s & src2[XLEN-1];
    assign mag1_s     = negate(src1, s1_neg_s);
    assign mag2_s     = negate(src2, s2_neg_s);
    assign div_zero_s = (src2 == {XLEN{1'b0}});
    assign div_ovf_s  = funct3[2] & ~funct3[0] & (src1 == {1'b1, {(XLEN-1){1'b0}}})
                        & (src2 == {XLEN{1'b1}});

`ifdef YSYX_23060236_MDU_FASTMUL_EN
    logic [2*XLEN-1:0] fast_prod_s;
    logic [2*XLEN-1:0] fast_sprod_s;
    assign fast_prod_s  = {{XLEN{1'b0}}, mag1_s} * {{XLEN{1'b0}}, mag2_s};
    assign fast_sprod_s = (s1_neg_s ^ s2_neg_s) ? (~fast_prod_s + (2*XLEN)'(1)) : fast_prod_s;
`endif

    // Results that bypass the iterative datapath (finish on the first BUSY edge)
    always_comb begin
        quick_s     = 1'b0;
        quick_res_s = {XLEN{1'b0}};
        if (funct3[2]) begin
            quick_s = div_zero_s | div_ovf_s;
            if (div_zero_s) begin
                quick_res_s = funct3[1] ? src1 : {XLEN{1'b1}};
            end else if (div_ovf_s) begin
                quick_res_s = funct3[1] ? {XLEN{1'b0}} : src1;
            end else begin
                quick_res_s = {XLEN{1'b0}};
            end
        end else begin
`ifdef YSYX_23060236_MDU_FASTMUL_EN
            quick_s     = 1'b1;
            quick_res_s = (funct3 == 3'd0) ? fast_sprod_s[XLEN-1:0] : fast_sprod_s[2*XLEN-1:XLEN];
`else
            quick_s     = 1'b0;
            quick_res_s = {XLEN{1'b0}};
`endif
        end
    end

    // One iteration of shift-add multiply and restoring divide; hi/lo hold product or rem/quotient
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN-1:0]   mul_hi_n_s;
    logic [XLEN-1:0]   mul_lo_n_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN:0]     div_diff_s;
    logic              div_ge_s;
    logic [XLEN-1:0]   div_hi_n_s;
    logic [XLEN-1:0]   div_lo_n_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] sprod_s;
    logic [XLEN-1:0]   iter_res_s;

    assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    assign mul_hi_n_s  = mul_sum_s[XLEN:1];
    assign mul_lo_n_s  = {mul_sum_s[0], lo_r[XLEN-1:1]};
    assign div_shift_s = {hi_r, lo_r[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
    assign div_ge_s    = ~div_diff_s[XLEN];
    assign div_hi_n_s  = div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
    assign div_lo_n_s  = {lo_r[XLEN-2:0], div_ge_s};
    assign prod_s      = {mul_hi_n_s, mul_lo_n_s};
    assign sprod_s     = q_neg_r ? (~prod_s + (2*XLEN)'(1)) : prod_s;

    // Final sign fix-up and half selection on the last iteration
    always_comb begin
        iter_res_s = {XLEN{1'b0}};
        if (f3_r[2]) begin
            iter_res_s = f3_r[1] ? negate(div_hi_n_s, r_neg_r) : negate(div_lo_n_s, q_neg_r);
        end else begin
            iter_res_s = (f3_r == 3'd0) ? sprod_s[XLEN-1:0] : sprod_s[2*XLEN-1:XLEN];
        end
    end

    assign in_ready = (state_r == IDLE);

    // Control FSM and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            result    <= {XLEN{1'b0}};
            rd_out    <= {TAG_W{1'b0}};
            cnt_r     <= {CW{1'b0}};
            f3_r      <= 3'd0;
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= {XLEN{1'b0}};
            opnd_r    <= {XLEN{1'b0}};
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            quick_r   <= 1'b0;
        end else if (flush) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            cnt_r     <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        state_r <= BUSY;
                        f3_r    <= funct3;
                        rd_out  <= rd_in;
                        cnt_r   <= {CW{1'b0}};
                        q_neg_r <= s1_neg_s ^ s2_neg_s;
                        r_neg_r <= s1_neg_s;
                        quick_r <= quick_s;
                        hi_r    <= quick_s ? quick_res_s : {XLEN{1'b0}};
                        lo_r    <= funct3[2] ? mag1_s : mag2_s;
                        opnd_r  <= funct3[2] ? mag2_s : mag1_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (quick_r) begin
                        result    <= hi_r;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        hi_r <= f3_r[2] ? div_hi_n_s : mul_hi_n_s;
                        lo_r <= f3_r[2] ? div_lo_n_s : mul_lo_n_s;
                        if (cnt_r == CW'(XLEN - 1)) begin
                            result    <= iter_res_s;
                            out_valid <= 1'b1;
                            state_r   <= DONE;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_mdu.sv
// Self-checking bench for ysyx_23060236_mdu: vector table plus scoreboard, and handshake/flush/reset sequences.
module tb_ysyx_23060236_mdu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  rd_out;

    ysyx_23060236_mdu #(.XLEN(32), .TAG_W(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .src1(src1), .src2(src2), .rd_in(rd_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd_out(rd_out)
    );

    always #5 clock = ~clock;

`ifdef YSYX_23060236_MDU_FASTMUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        int          lat;
    } sb_t;

    sb_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    // Drive one request with out_ready high, then check latency, result and tag from the scoreboard.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] t, input logic [31:0] exp);
        int edges;
        sb_t e;
        wait_ready();
        exp_q.push_back('{exp, t, lat_of(f, a, b)});
        in_valid = 1'b1; funct3 = f; src1 = a; src2 = b; rd_in = t;
        @(posedge clock); #1;
        in_valid = 1'b0; src1 = $urandom; src2 = $urandom; rd_in = 4'($urandom);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clock); #1;
            edges++;
        end
        e = exp_q.pop_front();
        check("latency", 64'(edges), 64'(e.lat));
        check("result", 64'(result), 64'(e.res));
        check("rd_out", 64'(rd_out), 64'(e.tag));
        @(posedge clock); #1;
        check("idle_after_handshake", 64'({out_valid, in_ready}), 64'b01);
    endtask

    vec_t tbl[14];

    initial begin
        logic [31:0] held_res;
        logic [3:0]  held_tag;
        int          seen;
        int          edges;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 4'h1, 32'h4000_0000};
        tbl[1]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 4'h2, 32'hFFFF_FFFD};
        tbl[2]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 4'h3, 32'hFFFF_FFFF};
        tbl[3]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 4'h4, 32'hFFFF_FFFF};
        tbl[4]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 4'h5, 32'h0000_0005};
        tbl[5]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'h6, 32'h8000_0000};
        tbl[6]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'h7, 32'h0000_0000};
        tbl[7]  = '{3'd0, 32'h0000_0003, 32'hFFFF_FFFB, 4'h8, 32'hFFFF_FFF1};
        tbl[8]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 4'h9, 32'hFFFF_FFFF};
        tbl[9]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hA, 32'hFFFF_FFFE};
        tbl[10] = '{3'd4, 32'h0000_0007, 32'h0000_0000, 4'hB, 32'hFFFF_FFFF};
        tbl[11] = '{3'd6, 32'hFFFF_FFF7, 32'h0000_0000, 4'hC, 32'hFFFF_FFF7};
        tbl[12] = '{3'd5, 32'h0000_0064, 32'h0000_0007, 4'hD, 32'h0000_000E};
        tbl[13] = '{3'd7, 32'h0000_0064, 32'h0000_0007, 4'hE, 32'h0000_0002};

        reset = 1'b0; in_valid = 1'b0; funct3 = 3'd0; src1 = 32'd0; src2 = 32'd0;
        rd_in = 4'd0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 64'({out_valid, result, rd_out}), 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp);
        end

        for (int i = 0; i < 16; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 5 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            run_op(rf, ra, rb, 4'(i), model(rf, ra, rb));
        end

        // DONE held while out_ready is low
        out_ready = 1'b0;
        wait_ready();
        in_valid = 1'b1; funct3 = 3'd4; src1 = 32'hFFFF_FFF9; src2 = 32'd2; rd_in = 4'h9;
        @(posedge clock); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clock); #1;
            edges++;
        end
        check("stall_latency", 64'(edges), 64'd32);
        held_res = result;
        held_tag = rd_out;
        check("stall_first_result", 64'(held_res), 64'h0000_0000_FFFF_FFFD);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check("stall_hold", 64'({out_valid, in_ready, result, rd_out}),
                  64'({1'b1, 1'b0, 32'hFFFF_FFFD, 4'h9}));
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("stall_release", 64'({out_valid, in_ready}), 64'b01);

        // Flush on BUSY cycle 10 with a competing request
        wait_ready();
        in_valid = 1'b1; funct3 = 3'd4; src1 = 32'd1000; src2 = 32'd3; rd_in = 4'h4;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("flush_still_busy", 64'({out_valid, in_ready}), 64'b00);
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'd5; src1 = 32'd8; src2 = 32'd2; rd_in = 4'h7;
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle", 64'({out_valid, in_ready}), 64'b01);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (out_valid || !in_ready) seen++;
        end
        check("flush_no_output", 64'(seen), 64'd0);

        // Reset in the middle of an operation
        in_valid = 1'b1; funct3 = 3'd5; src1 = 32'd77; src2 = 32'd5; rd_in = 4'h3;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        check("midreset_clear", 64'({out_valid, in_ready, result, rd_out}), 64'({1'b0, 1'b1, 32'd0, 4'd0}));
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        check("midreset_no_output", 64'(seen), 64'd0);

        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 4'hF, 32'h4000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_23060236_mdu.md
YSYX_23060236_MDU -- requirements
Module: ysyx_23060236_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (any even value >= 8).
REQ-002 SHALL have parameter TAG_W, default 4, width of destination-register tag passed through.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port funct3  input  3  RV M-extension op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have ports src1, src2  input  XLEN each  operands (rs1, rs2).
REQ-009 SHALL have port rd_in  input  TAG_W  destination tag.
REQ-010 SHALL have port flush  input  1  kill the in-flight operation (mispredict or fence.i).
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have ports result  output  XLEN  and rd_out  output  TAG_W  registered result and tag.

Function
REQ-014 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE; in_ready = (state == IDLE).
REQ-015 SHALL accept a request when in_valid & in_ready on an edge, latching funct3, rd_in, operand magnitudes and result sign.
REQ-016 SHALL compute MUL as an iterative shift-add (1 bit per cycle) over magnitudes and negate when the sign is set; MULH/MULHSU/MULHU return the upper XLEN bits of the 2*XLEN product, MUL the lower XLEN bits.
REQ-017 SHALL compute DIV/REM as restoring division (1 quotient bit per cycle); the remainder sign follows the dividend and the quotient sign is sign(src1) XOR sign(src2).
REQ-018 SHALL use a cycle counter of ceil(log2(XLEN+1)) bits; BUSY runs exactly XLEN iterations, and out_valid rises after the XLEN-th edge following the accept edge.
REQ-019 SHALL treat divide-by-zero as quotient all-ones and remainder = src1, with out_valid after the first edge following accept.
REQ-020 SHALL treat signed overflow (src1 = most-negative, src2 = -1) as quotient = src1 and remainder 0, with out_valid after the first edge following accept.
REQ-021 SHALL hold result, rd_out and out_valid stable in DONE until out_valid & out_ready, then go to IDLE on that edge (one-cycle bubble before the next accept).
REQ-022 SHALL, when flush = 1 on an edge, go to IDLE with out_valid = 0 regardless of state; flush takes priority over a simultaneous accept, which is discarded.
REQ-023 SHALL ignore in_valid while not in IDLE; operand inputs need not be held after accept.

Reset
REQ-024 SHALL, on an edge with reset = 0, set state IDLE, out_valid 0, result 0, rd_out 0 and counter 0, taking priority over flush and all handshakes.
REQ-025 SHALL drive in_ready = 1 on the first edge after reset deasserts; reset mid-BUSY abandons the operation with no output.

Configuration
REQ-026 SHALL honour macro YSYX_23060236_MDU_FASTMUL_EN: when defined, MUL* ops use a single-cycle combinational XLEN x XLEN product with out_valid after the first edge following accept; when undefined, they use the iterative path of REQ-016/REQ-018. Division is iterative in both cases.

Verification
REQ-027 SHALL cover MULH with XLEN = 32, src1 = 0x80000000, src2 = 0x80000000 -> result 0x40000000 after 32 edges (1 edge with FASTMUL).
REQ-028 SHALL cover DIV with src1 = -7, src2 = 2 -> result 0xFFFFFFFD, and REM -> 0xFFFFFFFF, each after 32 edges.
REQ-029 SHALL cover DIVU with src2 = 0, src1 = 5 -> result 0xFFFFFFFF after 1 edge, and REMU -> 5.
REQ-030 SHALL cover DIV with 0x80000000 / 0xFFFFFFFF -> result 0x80000000, and REM -> 0, each after 1 edge.
REQ-031 SHALL cover out_ready held 0 for 5 cycles in DONE -> result and rd_out unchanged, out_valid high; with out_ready = 1, IDLE next cycle.
REQ-032 SHALL cover flush asserted on BUSY cycle 10 of DIV, with in_valid simultaneously high -> no out_valid, in_ready = 1 the next cycle, and the new request not accepted.
